// File: rtl/pzcorebus_bundled_request_arbiter.sv
// Round-robin merge of bundled corebus request channels onto one master port; write data follows command order.
// Zero-cycle combinational datapaths; a channel sees accept only while it holds the command grant or the write-queue head.
module pzcorebus_bundled_request_arbiter #(
   parameter int CHANNELS            = 2,
   parameter int COMMAND_WIDTH       = 64,
   parameter int WRITE_DATA_WIDTH    = 64,
   parameter int RESPONSE_WIDTH      = 64,
   parameter int WRITE_QUEUE_DEPTH   = 4,
   localparam int CHANNEL_INDEX_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst_n,
   input  logic [CHANNELS-1:0]                        i_mcmd_valid,
   output logic [CHANNELS-1:0]                        o_scmd_accept,
   input  logic [CHANNELS-1:0][COMMAND_WIDTH-1:0]     i_mcmd,
   input  logic [CHANNELS-1:0]                        i_mcmd_write,
   input  logic [CHANNELS-1:0]                        i_mdata_valid,
   output logic [CHANNELS-1:0]                        o_sdata_accept,
   input  logic [CHANNELS-1:0][WRITE_DATA_WIDTH-1:0]  i_mdata,
   input  logic [CHANNELS-1:0]                        i_mdata_last,
   output logic                                       o_mcmd_valid,
   input  logic                                       i_scmd_accept,
   output logic [COMMAND_WIDTH-1:0]                   o_mcmd,
   output logic [CHANNEL_INDEX_WIDTH-1:0]             o_mcmd_channel,
   output logic                                       o_mdata_valid,
   input  logic                                       i_sdata_accept,
   output logic [WRITE_DATA_WIDTH-1:0]                o_mdata,
   output logic                                       o_mdata_last,
   input  logic                                       i_sresp_valid,
   output logic                                       o_mresp_accept,
   input  logic [RESPONSE_WIDTH-1:0]                  i_sresp,
   input  logic [CHANNEL_INDEX_WIDTH-1:0]             i_sresp_channel,
   output logic [CHANNELS-1:0]                        o_sresp_valid,
   input  logic [CHANNELS-1:0]                        i_mresp_accept,
   output logic [CHANNELS-1:0][RESPONSE_WIDTH-1:0]    o_sresp
);

   localparam int CIW = CHANNEL_INDEX_WIDTH;
   localparam int QPW = (WRITE_QUEUE_DEPTH > 1) ? $clog2(WRITE_QUEUE_DEPTH) : 1;
   localparam int QCW = $clog2(WRITE_QUEUE_DEPTH + 1);

   typedef logic [CIW-1:0] chan_t;
   typedef logic [QPW-1:0] qptr_t;

   function automatic chan_t wrap_index(input int unsigned idx);
      return chan_t'(idx % CHANNELS);
   endfunction

   function automatic qptr_t next_ptr(input qptr_t p);
      return (p == qptr_t'(WRITE_QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   chan_t            r_rr;
   logic             r_grant_lock;
   chan_t            r_lock_index;
   chan_t            r_queue [WRITE_QUEUE_DEPTH];
   qptr_t            r_rd_ptr;
   qptr_t            r_wr_ptr;
   logic [QCW-1:0]   r_count;

   logic                w_queue_full;
   logic                w_queue_busy;
   logic [CHANNELS-1:0] w_eligible;
   chan_t               w_grant;
   logic                w_grant_vld;
   logic                w_cmd_ack;
   logic                w_push;
   logic                w_pop;
   chan_t               w_head;
   logic                w_data_vld;

   // Full is judged on the registered count, so a pop in the same cycle never admits a write.
   assign w_queue_full = (r_count == QCW'(WRITE_QUEUE_DEPTH));
   assign w_queue_busy = (r_count != '0);
   assign w_eligible   = i_mcmd_valid & ~(i_mcmd_write & {CHANNELS{w_queue_full}});

   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = '0;
      if (r_grant_lock) begin
         w_grant_vld = i_mcmd_valid[r_lock_index];
         w_grant     = r_lock_index;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!w_grant_vld && w_eligible[wrap_index(int'(r_rr) + i)]) begin
               w_grant_vld = 1'b1;
               w_grant     = wrap_index(int'(r_rr) + i);
            end
         end
      end
   end

   assign w_cmd_ack  = w_grant_vld && i_scmd_accept;
   assign w_push     = w_cmd_ack && i_mcmd_write[w_grant];
   assign w_head     = r_queue[r_rd_ptr];
   assign w_data_vld = w_queue_busy && i_mdata_valid[w_head];
   assign w_pop      = w_data_vld && i_sdata_accept && i_mdata_last[w_head];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rr         <= '0;
         r_grant_lock <= 1'b0;
         r_lock_index <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
      end else begin
         if (w_cmd_ack) begin
            r_rr         <= wrap_index(int'(w_grant) + 1);
            r_grant_lock <= 1'b0;
         end else if (w_grant_vld) begin
            r_grant_lock <= 1'b1;
            r_lock_index <= w_grant;
         end
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_queue[r_wr_ptr] <= w_grant;
      end
   end

   assign o_mcmd         = i_mcmd[w_grant];
   assign o_mcmd_channel = w_grant;
   assign o_mdata        = i_mdata[w_head];
   assign o_mdata_last   = i_mdata_last[w_head];
   assign o_sresp        = {CHANNELS{i_sresp}};

   // Out-of-range response indices match no channel and are sunk with accept=1.
   always_comb begin
      o_mcmd_valid   = w_grant_vld;
      o_mdata_valid  = w_data_vld;
      o_scmd_accept  = '0;
      o_sdata_accept = '0;
      o_sresp_valid  = '0;
      o_mresp_accept = 1'b1;
      if (w_grant_vld) begin
         o_scmd_accept[w_grant] = i_scmd_accept;
      end
      if (w_queue_busy) begin
         o_sdata_accept[w_head] = i_sdata_accept;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         if (i_sresp_channel == chan_t'(c)) begin
            o_sresp_valid[c] = i_sresp_valid;
            o_mresp_accept   = i_mresp_accept[c];
         end
      end
      if (!i_rst_n) begin
         o_mcmd_valid   = 1'b0;
         o_mdata_valid  = 1'b0;
         o_scmd_accept  = '0;
         o_sdata_accept = '0;
         o_sresp_valid  = '0;
         o_mresp_accept = 1'b0;
      end
   end

endmodule
